step_ctrl: RTL and testbench

Execution-control front end for `procesadorArm`. It synchronizes and debounces the `clk_step` pushbutton and the `clk_select` mode switch, and drives a one-bit clock enable into the core. The core either free-runs or advances exactly one cycle per button press. The block also counts enabled cycles and can halt the core when the PC reaches a programmed limit, so benches and the FPGA top stop cleanly after the last instruction.

---
 rtl/step_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_step_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// step_ctrl: debounced single-step / free-run clock-enable front end for the core.
// Define STEP_CTRL_HALT_EN to compile in the PC-limit comparator and the HALT state.
module step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 32,
  parameter int PC_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_step,
  input  logic             clk_select,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [PC_W-1:0]  halt_pc_i,
  output logic             cpu_en,
  output logic             step_ack,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_IDLE     = 3'd1,
    ST_STEP     = 3'd2,
    ST_WAIT_REL = 3'd3
`ifdef STEP_CTRL_HALT_EN
    , ST_HALT   = 3'd4
`endif
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  logic             step_meta_r;
  logic             step_sync_r;
  logic             sel_meta_r;
  logic             sel_sync_r;
  logic [DB_W-1:0]  db_cnt_r;
  logic [DB_W-1:0]  db_cnt_nxt_s;
  logic             db_lvl_r;
  logic             db_lvl_nxt_s;
  logic             db_lvl_d_r;
  logic             press_s;
  state_t           state_r;
  state_t           mode_nxt_s;
  state_t           state_nxt_s;
  logic             en_nxt_s;
  logic             ack_nxt_s;
  logic             cpu_en_r;
  logic             step_ack_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-flop synchronizers for the asynchronous button and mode switch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_meta_r <= 1'b0;
      step_sync_r <= 1'b0;
      sel_meta_r  <= 1'b0;
      sel_sync_r  <= 1'b0;
    end else begin
      step_meta_r <= clk_step;
      step_sync_r <= step_meta_r;
      sel_meta_r  <= clk_select;
      sel_sync_r  <= sel_meta_r;
    end
  end

  // Debounce: count consecutive samples that disagree with the stable level.
  always_comb begin
    db_cnt_nxt_s = {DB_W{1'b0}};
    db_lvl_nxt_s = db_lvl_r;
    if (step_sync_r != db_lvl_r) begin
      if (db_cnt_r == DB_LAST) begin
        db_lvl_nxt_s = step_sync_r;
        db_cnt_nxt_s = {DB_W{1'b0}};
      end else begin
        db_lvl_nxt_s = db_lvl_r;
        db_cnt_nxt_s = db_cnt_r + DB_ONE;
      end
    end else begin
      db_lvl_nxt_s = db_lvl_r;
      db_cnt_nxt_s = {DB_W{1'b0}};
    end
  end

  // Debouncer state plus a delayed copy of the level for press-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_r   <= {DB_W{1'b0}};
      db_lvl_r   <= 1'b0;
      db_lvl_d_r <= 1'b0;
    end else begin
      db_cnt_r   <= db_cnt_nxt_s;
      db_lvl_r   <= db_lvl_nxt_s;
      db_lvl_d_r <= db_lvl_r;
    end
  end

  assign press_s = db_lvl_r & ~db_lvl_d_r;

  // Mode transitions; free-run wins over a coincident press while idle.
  always_comb begin
    mode_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!sel_sync_r) begin
          mode_nxt_s = ST_RUN;
        end else if (press_s) begin
          mode_nxt_s = ST_STEP;
        end else begin
          mode_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (sel_sync_r) begin
          mode_nxt_s = ST_IDLE;
        end else begin
          mode_nxt_s = ST_RUN;
        end
      end
      ST_STEP: mode_nxt_s = ST_WAIT_REL;
      ST_WAIT_REL: begin
        if (!db_lvl_r) begin
          mode_nxt_s = ST_IDLE;
        end else begin
          mode_nxt_s = ST_WAIT_REL;
        end
      end
`ifdef STEP_CTRL_HALT_EN
      ST_HALT: mode_nxt_s = ST_HALT;
`endif
      default: mode_nxt_s = ST_IDLE;
    endcase
  end

`ifdef STEP_CTRL_HALT_EN
  logic halt_hit_s;
  logic halted_r;

  assign halt_hit_s = (halt_pc_i != {PC_W{1'b0}}) && (pc_i >= halt_pc_i);

  // The PC limit overrides every other transition, including a pending press.
  always_comb begin
    state_nxt_s = mode_nxt_s;
    if (halt_hit_s) begin
      state_nxt_s = ST_HALT;
    end else begin
      state_nxt_s = mode_nxt_s;
    end
  end

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_r <= 1'b0;
    end else begin
      halted_r <= (state_nxt_s == ST_HALT);
    end
  end

  assign halted = halted_r;
`else
  logic unused_pc_s;

  assign unused_pc_s = ^{pc_i, halt_pc_i};

  // Without the halt option the mode logic alone decides the next state.
  always_comb begin
    state_nxt_s = mode_nxt_s;
  end

  assign halted = 1'b0;
`endif

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    en_nxt_s  = 1'b0;
    ack_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_RUN: begin
        en_nxt_s  = 1'b1;
        ack_nxt_s = 1'b0;
      end
      ST_STEP: begin
        en_nxt_s  = 1'b1;
        ack_nxt_s = 1'b1;
      end
      default: begin
        en_nxt_s  = 1'b0;
        ack_nxt_s = 1'b0;
      end
    endcase
  end

  // State register, registered enables and the saturating enabled-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cpu_en_r   <= 1'b0;
      step_ack_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      cpu_en_r   <= en_nxt_s;
      step_ack_r <= ack_nxt_s;
      if (cpu_en_r) begin
        cnt_r <= sat_inc(cnt_r);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign cpu_en      = cpu_en_r;
  assign step_ack    = step_ack_r;
  assign cycle_count = cnt_r;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: scenario tasks plus randomized traffic against a behavioural model of step_ctrl.
module tb_step_ctrl;

  localparam int DEB = 4;
  localparam int HL  = DEB + 2;
`ifdef STEP_CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_step;
  logic        clk_select;
  logic [31:0] pc_i;
  logic [31:0] halt_pc_i;
  logic        cpu_en, step_ack, halted;
  logic [31:0] cycle_count;
  logic        sat_en, sat_ack, sat_halted;
  logic [3:0]  sat_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model: raw-input history, debounced level and mode flags.
  bit     step_h [HL];
  bit     sel_h  [3];
  bit     m_lvl, m_lvl_d, m_run, m_pulse, m_hold, m_halted, m_en, m_ack;
  longint m_cnt;
  int     m_cnt4;

  always #5 clk = ~clk;

  step_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(32), .PC_W(32)) u_dut (
    .clk(clk), .rst(rst), .clk_step(clk_step), .clk_select(clk_select),
    .pc_i(pc_i), .halt_pc_i(halt_pc_i), .cpu_en(cpu_en), .step_ack(step_ack),
    .halted(halted), .cycle_count(cycle_count)
  );

  step_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4), .PC_W(32)) u_sat (
    .clk(clk), .rst(rst), .clk_step(clk_step), .clk_select(clk_select),
    .pc_i(pc_i), .halt_pc_i(halt_pc_i), .cpu_en(sat_en), .step_ack(sat_ack),
    .halted(sat_halted), .cycle_count(sat_cnt)
  );

  task automatic model_reset();
    for (int i = 0; i < HL; i++) step_h[i] = 1'b0;
    for (int i = 0; i < 3; i++) sel_h[i] = 1'b0;
    m_lvl = 0; m_lvl_d = 0; m_run = 0; m_pulse = 0; m_hold = 0;
    m_halted = 0; m_en = 0; m_ack = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic model_edge();
    bit sel_s, press, halt_now, en_new, ack_new, all_diff;
    for (int i = HL - 1; i > 0; i--) step_h[i] = step_h[i-1];
    step_h[0] = clk_step;
    sel_h[2] = sel_h[1]; sel_h[1] = sel_h[0]; sel_h[0] = clk_select;
    sel_s = sel_h[2];
    if (m_en) begin
      if (m_cnt < longint'(32'hFFFF_FFFF)) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    press    = m_lvl && !m_lvl_d;
    halt_now = HALT_EN && (halt_pc_i != 32'd0) && (pc_i >= halt_pc_i);
    ack_new  = 1'b0;
    if (m_halted) en_new = 1'b0;
    else if (halt_now) begin
      m_halted = 1'b1; m_run = 0; m_pulse = 0; m_hold = 0; en_new = 1'b0;
    end
    else if (m_run) begin m_run = !sel_s; en_new = m_run; end
    else if (m_pulse) begin m_pulse = 0; m_hold = 1; en_new = 1'b0; end
    else if (m_hold) begin m_hold = m_lvl; en_new = 1'b0; end
    else if (!sel_s) begin m_run = 1; en_new = 1'b1; end
    else if (press) begin m_pulse = 1; en_new = 1'b1; ack_new = 1'b1; end
    else en_new = 1'b0;
    all_diff = 1'b1;
    for (int i = 0; i < DEB; i++) if (step_h[2+i] == m_lvl) all_diff = 1'b0;
    m_lvl_d = m_lvl;
    if (all_diff) m_lvl = !m_lvl;
    m_en  = en_new;
    m_ack = ack_new;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clk_select = 1'b1; clk_step = 1'b0; pc_i = 32'd0; halt_pc_i = 32'd0;
    rst = 1'b1;
    #2;
    do_reset();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", cpu_en); end
    total++; if (step_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", step_ack); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
    total++; if (sat_cnt !== 4'd0) begin bad++; $display("FAIL reset_satcnt got=%0d exp=0", sat_cnt); end
  endtask

  task automatic test_free_run();
    longint base;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (cpu_en !== m_en) begin bad++; $display("FAIL settle_en cyc=%0d got=%b exp=%b", i, cpu_en, m_en); end
    end
    clk_select = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (cpu_en !== (i == 3)) begin bad++; $display("FAIL freerun_start cyc=%0d got=%b exp=%b", i, cpu_en, (i == 3)); end
    end
    base = m_cnt;
    for (int i = 0; i < 100; i++) tick();
    total++; if (cycle_count !== 32'(base + 100)) begin bad++; $display("FAIL freerun_count got=%0d exp=%0d", cycle_count, base + 100); end
  endtask

  task automatic test_step();
    longint base;
    clk_select = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (cpu_en !== (i != 3)) begin bad++; $display("FAIL run_to_idle cyc=%0d got=%b exp=%b", i, cpu_en, (i != 3)); end
    end
    for (int i = 0; i < 6; i++) tick();
    for (int p = 0; p < 2; p++) begin
      base = m_cnt;
      clk_step = 1'b1;
      for (int i = 1; i <= 35; i++) begin
        tick();
        if (i == 20) clk_step = 1'b0;
        total++; if (cpu_en !== (i == 7)) begin bad++; $display("FAIL step_en press=%0d cyc=%0d got=%b exp=%b", p, i, cpu_en, (i == 7)); end
        total++; if (step_ack !== (i == 7)) begin bad++; $display("FAIL step_ack press=%0d cyc=%0d got=%b exp=%b", p, i, step_ack, (i == 7)); end
      end
      total++; if (cycle_count !== 32'(base + 1)) begin bad++; $display("FAIL step_count press=%0d got=%0d exp=%0d", p, cycle_count, base + 1); end
    end
  endtask

  task automatic test_bounce();
    int acks;
    acks = 0;
    for (int i = 0; i < 45; i++) begin
      if (i < 10) clk_step = (i % 2 == 0);
      else if (i < 30) clk_step = 1'b1;
      else clk_step = 1'b0;
      tick();
      if (step_ack) acks++;
      total++; if (step_ack !== (i == 16)) begin bad++; $display("FAIL bounce_ack cyc=%0d got=%b exp=%b", i + 1, step_ack, (i == 16)); end
      total++; if (cpu_en !== m_en) begin bad++; $display("FAIL bounce_en cyc=%0d got=%b exp=%b", i + 1, cpu_en, m_en); end
    end
    total++; if (acks != 1) begin bad++; $display("FAIL bounce_count got=%0d exp=1", acks); end
    for (int i = 0; i < 20; i++) begin
      clk_step = (i < 3);
      tick();
      total++; if (step_ack !== 1'b0) begin bad++; $display("FAIL glitch_ack cyc=%0d got=%b exp=0", i + 1, step_ack); end
    end
  endtask

  task automatic test_reset_mid_step();
    clk_step = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL midreset_en got=%b exp=0", cpu_en); end
    total++; if (step_ack !== 1'b0) begin bad++; $display("FAIL midreset_ack got=%b exp=0", step_ack); end
    total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL midreset_count got=%0d exp=0", cycle_count); end
    tick();
    rst = 1'b1;
    clk_step = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++; if (cpu_en !== m_en) begin bad++; $display("FAIL postreset_en cyc=%0d got=%b exp=%b", i, cpu_en, m_en); end
    end
  endtask

  task automatic test_halt();
    bit prev_en;
    bit found;
    clk_select = 1'b0; halt_pc_i = 32'd0; pc_i = 32'd0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      prev_en = cpu_en;
      tick();
      if (prev_en) pc_i = pc_i + 32'd4;
      if (i >= 1) begin
        total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL nohalt_pc0_en cyc=%0d pc=%0d got=%b exp=1", i, pc_i, cpu_en); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL nohalt_pc0_halted cyc=%0d got=%b exp=0", i, halted); end
      end
    end
    halt_pc_i = 32'd840; pc_i = 32'd0;
    do_reset();
`ifdef STEP_CTRL_HALT_EN
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      prev_en = cpu_en;
      tick();
      if (prev_en) pc_i = pc_i + 32'd4;
      if (pc_i == 32'd840) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL halt_reach got=%0d exp=840", pc_i); end
    total++; if (cpu_en !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL halt_pre got=%b/%b exp=1/0", cpu_en, halted); end
    tick();
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL halt_en got=%b exp=0", cpu_en); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
    total++; if (cycle_count !== 32'd211) begin bad++; $display("FAIL halt_count got=%0d exp=211", cycle_count); end
    for (int i = 0; i < 40; i++) begin
      clk_step = ((i / 12) % 2 == 1);
      clk_select = ((i / 7) % 2 == 1);
      tick();
      total++; if (cpu_en !== 1'b0 || step_ack !== 1'b0) begin bad++; $display("FAIL halt_hold cyc=%0d got=%b/%b exp=0/0", i, cpu_en, step_ack); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_sticky cyc=%0d got=%b exp=1", i, halted); end
    end
    total++; if (cycle_count !== 32'd211) begin bad++; $display("FAIL halt_count_hold got=%0d exp=211", cycle_count); end
`else
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      prev_en = cpu_en;
      tick();
      if (prev_en) pc_i = pc_i + 32'd4;
      if (pc_i > 32'd840) found = 1'b1;
      if (i >= 1) begin
        total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL nohalt_en cyc=%0d pc=%0d got=%b exp=1", i, pc_i, cpu_en); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL nohalt_halted cyc=%0d got=%b exp=0", i, halted); end
      end
    end
    total++; if (!found) begin bad++; $display("FAIL nohalt_sweep got=%0d exp=>840", pc_i); end
`endif
    clk_step = 1'b0; clk_select = 1'b1; halt_pc_i = 32'd0; pc_i = 32'd0;
  endtask

  task automatic test_saturation();
    clk_select = 1'b0; clk_step = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    total++; if (sat_cnt !== 4'd15) begin bad++; $display("FAIL sat_count got=%0d exp=15", sat_cnt); end
    total++; if (cycle_count !== 32'd19) begin bad++; $display("FAIL sat_wide_count got=%0d exp=19", cycle_count); end
  endtask

  task automatic test_random();
    int  step_left, sel_left;
    bit  prev_en;
    for (int seg = 0; seg < 6; seg++) begin
      clk_select = 1'($urandom_range(0, 1));
      clk_step = 1'b0;
      pc_i = 32'd0;
      halt_pc_i = (seg % 2 == 1) ? 32'($urandom_range(50, 300)) * 32'd4 : 32'd0;
      do_reset();
      step_left = 0;
      sel_left = $urandom_range(20, 120);
      for (int c = 0; c < 300; c++) begin
        prev_en = cpu_en;
        tick();
        if (prev_en) pc_i = pc_i + 32'd4;
        total++; if (cpu_en !== m_en) begin bad++; $display("FAIL rand_en seg=%0d cyc=%0d got=%b exp=%b", seg, c, cpu_en, m_en); end
        total++; if (step_ack !== m_ack) begin bad++; $display("FAIL rand_ack seg=%0d cyc=%0d got=%b exp=%b", seg, c, step_ack, m_ack); end
        total++; if (halted !== m_halted) begin bad++; $display("FAIL rand_halted seg=%0d cyc=%0d got=%b exp=%b", seg, c, halted, m_halted); end
        total++; if (cycle_count !== 32'(m_cnt)) begin bad++; $display("FAIL rand_count seg=%0d cyc=%0d got=%0d exp=%0d", seg, c, cycle_count, m_cnt); end
        total++; if (sat_cnt !== 4'(m_cnt4) || sat_en !== m_en || sat_ack !== m_ack || sat_halted !== m_halted) begin
          bad++; $display("FAIL rand_sat seg=%0d cyc=%0d got=%0d exp=%0d", seg, c, sat_cnt, m_cnt4);
        end
        if (step_left == 0) begin
          clk_step = 1'($urandom_range(0, 1));
          step_left = $urandom_range(1, 10);
        end else begin
          step_left--;
        end
        if (sel_left == 0) begin
          clk_select = ~clk_select;
          sel_left = $urandom_range(20, 120);
        end else begin
          sel_left--;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_step();
    test_bounce();
    test_reset_mid_step();
    test_halt();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
